// File: rtl/rr_merge_ctrl_pkg.sv
// Shared types and helpers for the round-robin merge controller.
package rr_merge_ctrl_pkg;

  typedef enum logic {OPEN, LOCKED} merge_state_t;

  // Source index width; a single source still needs one bit of index.
  function automatic int merge_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_merge_ctrl_if.sv
// Source/destination handshake bundle of the merge controller.
interface rr_merge_ctrl_if import rr_merge_ctrl_pkg::*; #(
  parameter int N = 4
) ();
  localparam int IW = merge_iw(N);

  logic [N-1:0]  src_rdys;
  logic [N-1:0]  src_acks;
  logic [N-1:0]  src_lasts;
  logic          dst_rdy;
  logic          dst_ack;
  logic          o_load;
  logic [N-1:0]  o_sel;
  logic [IW-1:0] o_src_id;

  modport master (
    input  src_rdys, src_lasts, dst_ack,
    output src_acks, dst_rdy, o_load, o_sel, o_src_id
  );

  modport slave (
    output src_rdys, src_lasts, dst_ack,
    input  src_acks, dst_rdy, o_load, o_sel, o_src_id
  );
endinterface

// File: rtl/rr_merge_ctrl_pick.sv
// Round-robin picker: first set request scanning from ptr upward with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  localparam int SW = IW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  off;
  logic [SW-1:0]  sum;

  always_comb begin
    // Rotating the doubled vector puts ptr at bit 0, so a plain LSB-first
    // priority encode yields the distance from ptr to the winner.
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SW'(i);
        any = 1'b1;
      end
    end
    sum = off + {1'b0, ptr};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_idx = sum[IW-1:0];
    gnt     = any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/rr_merge_ctrl.sv
// N-to-1 rdy/ack merge: round-robin arbitration into one registered output
// slot, with optional burst lock keeping a source's packet contiguous.
module rr_merge_ctrl import rr_merge_ctrl_pkg::*; #(
  parameter int N    = 4,
  parameter bit LOCK = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rr_merge_ctrl_if.master bus
);
  localparam int IW = merge_iw(N);

  logic [IW-1:0] ptr;
  merge_state_t  state;
  logic          dst_rdy_q;
  logic [IW-1:0] src_id_q;

  logic [N-1:0]  elig;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          any;
  logic          free;
  logic          accept;
  logic          last_g;

  // Once locked only the owning source can win, so the scan start is its index.
  assign elig   = (state == LOCKED) ? (N'(1) << ptr) : '1;
  assign req    = elig & bus.src_rdys;
  assign free   = !dst_rdy_q || bus.dst_ack;
  assign accept = !i_rst && free && any;
  assign last_g = |(bus.src_lasts & gnt);

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .any     (any)
  );

  assign bus.src_acks = accept ? gnt : '0;
  assign bus.o_sel    = accept ? gnt : '0;
  assign bus.o_load   = accept;
  assign bus.dst_rdy  = dst_rdy_q;
  assign bus.o_src_id = src_id_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dst_rdy_q <= 1'b0;
      src_id_q  <= '0;
      ptr       <= '0;
      state     <= OPEN;
    end else begin
      dst_rdy_q <= accept || (dst_rdy_q && !bus.dst_ack);
      if (accept) begin
        src_id_q <= gidx;
        if (!LOCK || last_g) begin
          ptr   <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
          state <= OPEN;
        end else begin
          ptr   <= gidx;
          state <= LOCKED;
        end
      end
    end
  end
endmodule
